// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the front-end fetch stage: the fetch controller state
// encoding and the instruction size used to step the program counter.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   // Fetch controller states: idle (no requests), request issue, response wait.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_e;

   // Bytes per instruction; the PC advances by this after each accepted fetch.
   localparam int unsigned INSTR_BYTES = 32'd4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Front-end fetch stage. Holds the program counter, issues one outstanding read
// at a time to instruction memory and presents each returned instruction, with
// its PC, to the downstream fetch buffer under a valid/ready handshake.
// Redirects reload the PC, flush the held instruction and squash any response
// still in flight.
//
// Ports:
//   clock               single clock, all state updates on posedge
//   reset               synchronous, active-high
//   start               leave IDLE and begin fetching at the current PC
//   redirect            control-flow change this cycle
//   redirect_PC         new fetch address when redirect=1
//   i_mem_read          request strobe to instruction memory (combinational)
//   i_mem_read_address  request address, always the current fetch PC
//   i_mem_ready         memory accepts the request this cycle
//   i_mem_valid         response data valid this cycle
//   i_mem_data          response instruction
//   instruction         held instruction for the fetch buffer (registered)
//   inst_PC             PC of the held instruction (registered)
//   valid               instruction/inst_PC meaningful (registered)
//   ready               downstream consumes the held instruction when valid
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                       CORE            = 32'sd0,
   parameter int                       DATA_WIDTH      = 32'sd32,
   parameter int                       ADDRESS_BITS    = 32'sd20,
   parameter logic [ADDRESS_BITS-1:0]  PROGRAM_ADDRESS = {ADDRESS_BITS{1'b0}}
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      redirect,
   input  logic [ADDRESS_BITS-1:0]   redirect_PC,
   output logic                      i_mem_read,
   output logic [ADDRESS_BITS-1:0]   i_mem_read_address,
   input  logic                      i_mem_ready,
   input  logic                      i_mem_valid,
   input  logic [DATA_WIDTH-1:0]     i_mem_data,
   output logic [DATA_WIDTH-1:0]     instruction,
   output logic [ADDRESS_BITS-1:0]   inst_PC,
   output logic                      valid,
   input  logic                      ready
);

   // Core index is informational only; folded into a deliberately unused tap.
   logic unused_core_s;
   assign unused_core_s = ^CORE;

   fetch_state_e              state_r;
   fetch_state_e              state_nxt_s;
   logic [ADDRESS_BITS-1:0]   fetch_pc_r;
   logic [ADDRESS_BITS-1:0]   fetch_pc_nxt_s;
   logic                      squash_r;
   logic                      squash_nxt_s;
   logic                      valid_r;
   logic                      valid_nxt_s;
   logic [DATA_WIDTH-1:0]     instruction_r;
   logic [DATA_WIDTH-1:0]     instruction_nxt_s;
   logic [ADDRESS_BITS-1:0]   inst_pc_r;
   logic [ADDRESS_BITS-1:0]   inst_pc_nxt_s;
   logic                      mem_read_s;

   // Request gate: only issue when the output slot is empty or draining this
   // cycle, so the eventual response always has somewhere to land.
   always_comb begin
      mem_read_s = 1'b0;
      if (state_r == ST_REQ) begin
         mem_read_s = (!valid_r || ready) && !redirect;
      end else begin
         mem_read_s = 1'b0;
      end
   end

   assign i_mem_read         = mem_read_s;
   assign i_mem_read_address = fetch_pc_r;
   assign instruction        = instruction_r;
   assign inst_PC            = inst_pc_r;
   assign valid              = valid_r;

   // Next-state, PC, squash and output-slot update for the fetch controller.
   always_comb begin
      state_nxt_s       = state_r;
      fetch_pc_nxt_s    = fetch_pc_r;
      squash_nxt_s      = squash_r;
      instruction_nxt_s = instruction_r;
      inst_pc_nxt_s     = inst_pc_r;
      // Baseline drain; a load or flush below overrides it.
      if (valid_r && ready) begin
         valid_nxt_s = 1'b0;
      end else begin
         valid_nxt_s = valid_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (redirect) begin
               fetch_pc_nxt_s = redirect_PC;
            end else begin
               fetch_pc_nxt_s = fetch_pc_r;
            end
            if (start) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_REQ: begin
            if (redirect) begin
               // Request already suppressed by the gate; retarget and flush.
               fetch_pc_nxt_s = redirect_PC;
               valid_nxt_s    = 1'b0;
            end else if (mem_read_s && i_mem_ready) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end

         ST_WAIT: begin
            if (i_mem_valid) begin
               state_nxt_s  = ST_REQ;
               squash_nxt_s = 1'b0;
               if (redirect) begin
                  // Response for the old path arrives with the redirect: drop it.
                  fetch_pc_nxt_s = redirect_PC;
                  valid_nxt_s    = 1'b0;
               end else if (squash_r) begin
                  // Stale response from before an earlier redirect: drop it.
                  fetch_pc_nxt_s = fetch_pc_r;
               end else begin
                  instruction_nxt_s = i_mem_data;
                  inst_pc_nxt_s     = fetch_pc_r;
                  valid_nxt_s       = 1'b1;
                  fetch_pc_nxt_s    = fetch_pc_r + ADDRESS_BITS'(INSTR_BYTES);
               end
            end else if (redirect) begin
               // Response still outstanding; remember to discard it.
               squash_nxt_s   = 1'b1;
               fetch_pc_nxt_s = redirect_PC;
               valid_nxt_s    = 1'b0;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end

         default: begin
            state_nxt_s    = ST_IDLE;
            squash_nxt_s   = 1'b0;
            valid_nxt_s    = 1'b0;
         end
      endcase
   end

   // Controller and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         fetch_pc_r    <= PROGRAM_ADDRESS;
         squash_r      <= 1'b0;
         valid_r       <= 1'b0;
         instruction_r <= {DATA_WIDTH{1'b0}};
         inst_pc_r     <= {ADDRESS_BITS{1'b0}};
      end else begin
         state_r       <= state_nxt_s;
         fetch_pc_r    <= fetch_pc_nxt_s;
         squash_r      <= squash_nxt_s;
         valid_r       <= valid_nxt_s;
         instruction_r <= instruction_nxt_s;
         inst_pc_r     <= inst_pc_nxt_s;
      end
   end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: a memory responder with selectable
// latency, a transaction-level reference model compared every cycle, and
// directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [19:0] PROG = 20'h00100;

   typedef struct packed {
      logic [19:0] pc;
      logic [31:0] data;
   } item_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        redirect;
   logic [19:0] redirect_PC;
   logic        i_mem_read;
   logic [19:0] i_mem_read_address;
   logic        i_mem_ready;
   logic        i_mem_valid = 1'b0;
   logic [31:0] i_mem_data  = 32'h0;
   logic [31:0] instruction;
   logic [19:0] inst_PC;
   logic        valid;
   logic        ready;

   int checks = 0;
   int errors = 0;

   fetch_unit #(
      .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .PROGRAM_ADDRESS(PROG)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .redirect(redirect),
      .redirect_PC(redirect_PC), .i_mem_read(i_mem_read),
      .i_mem_read_address(i_mem_read_address), .i_mem_ready(i_mem_ready),
      .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data),
      .instruction(instruction), .inst_PC(inst_PC), .valid(valid), .ready(ready)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [19:0] a);
      return {12'hABC, a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction memory responder ----------------
   int          mem_lat = 1;
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [19:0] pend_addr = 20'h0;
   logic [19:0] req_log[$];

   always @(posedge clock) begin
      bit          acc;
      logic [19:0] a;
      acc = (i_mem_read === 1'b1) && (i_mem_ready === 1'b1);
      a   = i_mem_read_address;
      #1;
      i_mem_valid = 1'b0;
      i_mem_data  = 32'h0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            pend        = 1'b0;
            i_mem_valid = 1'b1;
            i_mem_data  = mem_word(pend_addr);
         end
      end
      if (acc) begin
         req_log.push_back(a);
         if (mem_lat <= 1) begin
            i_mem_valid = 1'b1;
            i_mem_data  = mem_word(a);
         end else begin
            pend      = 1'b1;
            cnt       = mem_lat - 1;
            pend_addr = a;
         end
      end
   end

   // ---------------- transaction-level reference model ----------------
   bit          live = 1'b0;
   bit          running = 1'b0;
   bit          outstanding = 1'b0;
   bit          alive = 1'b0;
   logic [19:0] pc_m = PROG;
   logic [19:0] req_addr = 20'h0;
   item_t       held[$];
   item_t       cons_log[$];

   always @(posedge clock) begin
      bit hv;
      bit fire;
      if (valid === 1'b1 && ready === 1'b1) cons_log.push_back({inst_PC, instruction});
      if (reset) begin
         live        = 1'b1;
         running     = 1'b0;
         outstanding = 1'b0;
         alive       = 1'b0;
         pc_m        = PROG;
         held.delete();
      end else if (live) begin
         hv   = held.size() != 0;
         fire = running && !outstanding && (!hv || ready) && !redirect && i_mem_ready;
         if (hv && ready) void'(held.pop_front());
         if (outstanding && i_mem_valid) begin
            outstanding = 1'b0;
            if (alive && !redirect) begin
               held.push_back({req_addr, mem_word(req_addr)});
               pc_m = req_addr + 20'd4;
            end
         end
         if (redirect) begin
            pc_m = redirect_PC;
            held.delete();
            if (outstanding) alive = 1'b0;
         end
         if (!running && start) running = 1'b1;
         if (fire) begin
            outstanding = 1'b1;
            alive       = 1'b1;
            req_addr    = pc_m;
         end
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clock) begin
      bit ev;
      bit er;
      if (live) begin
         ev = held.size() != 0;
         check("valid", valid, ev);
         if (ev) begin
            check("inst_PC", inst_PC, held[0].pc);
            check("instruction", instruction, held[0].data);
         end
         er = running && !outstanding && (!ev || ready) && !redirect;
         check("i_mem_read", i_mem_read, er);
         check("i_mem_read_address", i_mem_read_address, pc_m);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
      req_log.delete();
      cons_log.delete();
   endtask

   task automatic wait_req(input int n, input string name);
      int k = 0;
      while (req_log.size() < n && k < 60) begin
         tick();
         k++;
      end
      check({name, "_req_timeout"}, req_log.size() >= n, 1'b1);
   endtask

   task automatic wait_cons(input int n, input string name);
      int k = 0;
      while (cons_log.size() < n && k < 80) begin
         tick();
         k++;
      end
      check({name, "_cons_timeout"}, cons_log.size() >= n, 1'b1);
   endtask

   function automatic logic [19:0] req_at(input int i);
      if (req_log.size() > i) return req_log[i];
      return {20{1'bx}};
   endfunction

   function automatic item_t cons_at(input int i);
      if (cons_log.size() > i) return cons_log[i];
      return {52{1'bx}};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; redirect = 1'b0; redirect_PC = 20'h0;
      i_mem_ready = 1'b1; ready = 1'b1;

      // Reset state
      do_reset(3);
      check("rst_valid", valid, 1'b0);
      check("rst_instruction", instruction, 32'h0);
      check("rst_inst_PC", inst_PC, 20'h0);
      check("rst_read", i_mem_read, 1'b0);
      check("rst_address", i_mem_read_address, 20'h00100);

      // Sequential fetch, 1-cycle memory
      start = 1'b1; tick(); start = 1'b0;
      wait_cons(3, "seq");
      check("seq_req0", req_at(0), 20'h00100);
      check("seq_req1", req_at(1), 20'h00104);
      check("seq_req2", req_at(2), 20'h00108);
      check("seq_pc0", cons_at(0).pc, 20'h00100);
      check("seq_pc1", cons_at(1).pc, 20'h00104);
      check("seq_pc2", cons_at(2).pc, 20'h00108);
      check("seq_data2", cons_at(2).data, 32'hABC00108);

      // Backpressure: held output stable, no new request
      ready = 1'b0;
      begin
         int k = 0;
         while (valid !== 1'b1 && k < 20) begin tick(); k++; end
      end
      repeat (4) begin
         tick();
         check("stall_valid", valid, 1'b1);
         check("stall_pc", inst_PC, 20'h0010C);
         check("stall_data", instruction, 32'hABC0010C);
         check("stall_read", i_mem_read, 1'b0);
      end
      check("stall_reqcount", req_log.size(), 32'd4);
      ready = 1'b1;
      wait_cons(4, "stall");
      check("stall_cons_pc", cons_at(3).pc, 20'h0010C);

      // Redirect while waiting on 0x108 with 3-cycle memory
      mem_lat = 3;
      do_reset(5);
      start = 1'b1; tick(); start = 1'b0;
      wait_req(3, "redir");
      check("redir_req2", req_at(2), 20'h00108);
      redirect = 1'b1; redirect_PC = 20'h00200; tick(); redirect = 1'b0;
      wait_cons(3, "redir");
      check("redir_req3", req_at(3), 20'h00200);
      check("redir_pc", cons_at(2).pc, 20'h00200);
      check("redir_data", cons_at(2).data, 32'hABC00200);

      // Redirect coinciding with the response for 0x204
      wait_req(5, "coinc");
      check("coinc_req4", req_at(4), 20'h00204);
      tick(); tick();
      redirect = 1'b1; redirect_PC = 20'h00300; tick(); redirect = 1'b0;
      wait_cons(4, "coinc");
      check("coinc_req5", req_at(5), 20'h00300);
      check("coinc_pc", cons_at(3).pc, 20'h00300);
      check("coinc_data", cons_at(3).data, 32'hABC00300);

      // PC wrap at the top of the address space (redirect taken in IDLE)
      mem_lat = 1;
      do_reset(5);
      redirect = 1'b1; redirect_PC = 20'hFFFFC; tick(); redirect = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      wait_cons(2, "wrap");
      check("wrap_req0", req_at(0), 20'hFFFFC);
      check("wrap_req1", req_at(1), 20'h00000);
      check("wrap_pc0", cons_at(0).pc, 20'hFFFFC);
      check("wrap_pc1", cons_at(1).pc, 20'h00000);
      check("wrap_data1", cons_at(1).data, 32'hABC00000);

      // Reset during WAIT with the response landing the next cycle
      mem_lat = 2;
      do_reset(5);
      start = 1'b1; tick(); start = 1'b0;
      wait_req(1, "rstwait");
      reset = 1'b1; tick(); reset = 1'b0;
      repeat (6) begin
         tick();
         check("rstwait_valid", valid, 1'b0);
         check("rstwait_read", i_mem_read, 1'b0);
         check("rstwait_addr", i_mem_read_address, 20'h00100);
      end
      check("rstwait_reqcount", req_log.size(), 32'd1);
      start = 1'b1; tick(); start = 1'b0;
      wait_cons(1, "rstwait");
      check("rstwait_req1", req_at(1), 20'h00100);
      check("rstwait_pc", cons_at(0).pc, 20'h00100);
      check("rstwait_data", cons_at(0).data, 32'hABC00100);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fetch_unit
